fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage that owns the program counter and drives the single-cycle instruction memory (16-bit words, byte addresses, combinational read). It latches the returned word into the IF/ID pipeline register with a valid bit. It also handles decode stalls, branch/jump redirects from downstream, speculative HALT detection and misaligned-PC faults. It sits between the instruction memory and the decode stage.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0800, value driven on if_instr whenever IF/ID is empty or flushed.
HALT_OPC, 5'b00000, opcode (instr[15:11]) that stops fetch.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
imem_addr  out  16  byte address to instruction memory; always equals pc.
imem_en  out  1  memory enable; 1 only in RUN state.
imem_wr  out  1  tied 0; fetch never writes.
imem_rdata  in  16  combinational read data for imem_addr.
stall  in  1  decode cannot accept; hold PC and IF/ID.
redirect  in  1  taken branch/jump/exception from a later stage.
redirect_pc  in  16  new byte address, valid when redirect=1.
if_valid  out  1  IF/ID register holds a real instruction.
if_instr  out  16  fetched instruction.
if_pc  out  16  byte address of if_instr.
if_pc_plus2  out  16  if_pc + 2, modulo 2^16.
halted  out  1  fetch stopped on HALT opcode.
err  out  1  sticky misaligned-redirect fault.

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC; state=RUN; if_valid=0; if_instr=NOP_INSTR; if_pc=0; if_pc_plus2=0; halted=0; err=0. Reset asserted mid-fetch discards all state immediately.
- States: RUN, HALTED, ERR. imem_en=1 only in RUN. imem_addr=pc in all states.
- Per-cycle priority: redirect > stall > normal advance.
- Normal advance (RUN, no stall, no redirect):
  - pc <= pc+2 (wraps 16'hFFFE -> 16'h0000).
  - IF/ID <= {valid=1, imem_rdata, pc, pc+2}.
  - Fetch-to-IF/ID latency is 1 cycle.
- Stall (no redirect): pc and all IF/ID fields hold. No state change.
- Redirect with redirect_pc[0]=0, any state except ERR:
  - pc <= redirect_pc; if_valid <= 0; if_instr <= NOP_INSTR; state <= RUN; halted <= 0.
  - Applies even while stall=1.
  - Cancels a speculative HALT.
- Redirect with redirect_pc[0]=1, any state: err <= 1; state <= ERR; if_valid <= 0; pc holds. ERR exits only via reset.
- HALT: on a normal advance where imem_rdata[15:11]==HALT_OPC:
  - The HALT word is latched into IF/ID with valid=1.
  - pc <= pc+2; state <= HALTED; halted <= 1.
- HALTED:
  - imem_en=0 and pc holds.
  - When stall=0, if_valid <= 0 the cycle after the HALT word is consumed.
  - While stall=1, IF/ID holds the HALT word.
- pc[0] is always 0 outside ERR. RESET_PC must be even.
- imem_wr is constant 0, so no read/write conflict with the memory can arise.

Test Plan:
- Reset release with RESET_PC=0, memory words 0x0000..0x0006 = 4001,4202,4403,4604, stall=0 -> if_instr sequence 4001,4202,4403,4604 on cycles 1-4; if_pc 0,2,4,6; if_pc_plus2 2,4,6,8.
- stall=1 for 3 cycles with IF/ID holding pc=4 -> imem_addr stays 6; if_instr/if_pc stay unchanged; after release, pc=6 is delivered next cycle.
- redirect=1, redirect_pc=16'h0040, stall=1 in the same cycle -> next cycle if_valid=0, if_instr=0800, imem_addr=0040; the following cycle if_pc=0040.
- Word at 0x0008 = 0x0000 (HALT) -> if_valid=1, if_instr=0000, halted=1, imem_en=0; next cycle if_valid=0. Then redirect to 0x0010 -> halted=0, fetch resumes at 0x0010.
- redirect_pc=16'h0021 -> err=1, imem_en=0, if_valid=0; the state persists through a later valid redirect until rst=0.
- pc=16'hFFFE, no stall -> if_pc=FFFE, if_pc_plus2=0000, next imem_addr=0000. Assert rst mid-cycle -> outputs take reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads the instruction memory and fills
// the IF/ID register; handles stalls, redirects, HALT and misaligned faults.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    output logic        imem_en,
    output logic        imem_wr,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        ERR    = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [15:0] pc_inc;
    logic        valid_n;
    logic [15:0] instr_n;
    logic [15:0] ipc_n;
    logic [15:0] ipc2_n;
    logic        halted_n;
    logic        err_n;

    assign pc_inc    = pc + 16'd2;
    assign imem_addr = pc;
    assign imem_en   = (state == RUN);
    assign imem_wr   = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= NOP_INSTR;
            if_pc       <= 16'h0000;
            if_pc_plus2 <= 16'h0000;
            halted      <= 1'b0;
            err         <= 1'b0;
        end else begin
            pc          <= pc_n;
            if_valid    <= valid_n;
            if_instr    <= instr_n;
            if_pc       <= ipc_n;
            if_pc_plus2 <= ipc2_n;
            halted      <= halted_n;
            err         <= err_n;
        end
    end

    // Priority: misaligned redirect > redirect > stall > advance.
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        valid_n  = if_valid;
        instr_n  = if_instr;
        ipc_n    = if_pc;
        ipc2_n   = if_pc_plus2;
        halted_n = halted;
        err_n    = err;
        if (redirect && redirect_pc[0]) begin
            err_n   = 1'b1;
            state_n = ERR;
            valid_n = 1'b0;
            instr_n = NOP_INSTR;
        end else if (redirect && state != ERR) begin
            pc_n     = redirect_pc;
            valid_n  = 1'b0;
            instr_n  = NOP_INSTR;
            state_n  = RUN;
            halted_n = 1'b0;
        end else if (!stall) begin
            case (state)
                RUN: begin
                    pc_n    = pc_inc;
                    valid_n = 1'b1;
                    instr_n = imem_rdata;
                    ipc_n   = pc;
                    ipc2_n  = pc_inc;
                    if (imem_rdata[15:11] == HALT_OPC) begin
                        state_n  = HALTED;
                        halted_n = 1'b1;
                    end
                end
                HALTED: begin
                    valid_n = 1'b0;
                    instr_n = NOP_INSTR;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a behavioural
// combinational instruction memory.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_en;
    logic        imem_wr;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        halted;
    logic        err;

    logic [15:0] mem [0:32767];
    int          errors;
    int          checks;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_en     (imem_en),
        .imem_wr     (imem_wr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus2 (if_pc_plus2),
        .halted      (halted),
        .err         (err)
    );

    assign imem_rdata = mem[imem_addr[15:1]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, {15'd0, if_valid}, 16'h0000);
        chk({tag, ".instr"}, if_instr, 16'h0800);
        chk({tag, ".pc"}, if_pc, 16'h0000);
        chk({tag, ".pc2"}, if_pc_plus2, 16'h0000);
        chk({tag, ".halted"}, {15'd0, halted}, 16'h0000);
        chk({tag, ".err"}, {15'd0, err}, 16'h0000);
        chk({tag, ".addr"}, imem_addr, 16'h0000);
        chk({tag, ".en"}, {15'd0, imem_en}, 16'h0001);
        chk({tag, ".wr"}, {15'd0, imem_wr}, 16'h0000);
    endtask

    task automatic chk_ifid(input string tag, input logic v,
                            input logic [15:0] ins,
                            input logic [15:0] p,
                            input logic [15:0] p2);
        chk({tag, ".valid"}, {15'd0, if_valid}, {15'd0, v});
        chk({tag, ".instr"}, if_instr, ins);
        chk({tag, ".pc"}, if_pc, p);
        chk({tag, ".pc2"}, if_pc_plus2, p2);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'h4000 | 16'(i & 16'h07FF);
        end
        mem[0]      = 16'h4001;
        mem[1]      = 16'h4202;
        mem[2]      = 16'h4403;
        mem[3]      = 16'h4604;
        mem[4]      = 16'h0000;
        mem[8]      = 16'h4A10;
        mem[16'h20] = 16'h4820;
        mem[16'h7FFF] = 16'h4FFE;

        #12;
        chk_reset("reset");

        @(posedge clk);
        #1;
        rst = 1'b1;

        step();
        chk_ifid("f0", 1'b1, 16'h4001, 16'h0000, 16'h0002);
        step();
        chk_ifid("f1", 1'b1, 16'h4202, 16'h0002, 16'h0004);
        step();
        chk_ifid("f2", 1'b1, 16'h4403, 16'h0004, 16'h0006);
        chk("f2.addr", imem_addr, 16'h0006);

        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall.addr", imem_addr, 16'h0006);
            chk_ifid("stall", 1'b1, 16'h4403, 16'h0004, 16'h0006);
        end
        stall = 1'b0;
        step();
        chk_ifid("unstall", 1'b1, 16'h4604, 16'h0006, 16'h0008);

        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        stall       = 1'b1;
        step();
        chk("rd.valid", {15'd0, if_valid}, 16'h0000);
        chk("rd.instr", if_instr, 16'h0800);
        chk("rd.addr", imem_addr, 16'h0040);
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        chk_ifid("rd.fetch", 1'b1, 16'h4820, 16'h0040, 16'h0042);

        redirect    = 1'b1;
        redirect_pc = 16'h0008;
        step();
        redirect = 1'b0;
        chk("toh.valid", {15'd0, if_valid}, 16'h0000);
        chk("toh.addr", imem_addr, 16'h0008);
        step();
        chk_ifid("halt", 1'b1, 16'h0000, 16'h0008, 16'h000A);
        chk("halt.halted", {15'd0, halted}, 16'h0001);
        chk("halt.en", {15'd0, imem_en}, 16'h0000);
        chk("halt.addr", imem_addr, 16'h000A);
        stall = 1'b1;
        step();
        chk_ifid("halt.stall", 1'b1, 16'h0000, 16'h0008, 16'h000A);
        stall = 1'b0;
        step();
        chk("halt.drain.valid", {15'd0, if_valid}, 16'h0000);
        chk("halt.drain.instr", if_instr, 16'h0800);
        chk("halt.drain.addr", imem_addr, 16'h000A);
        chk("halt.drain.halted", {15'd0, halted}, 16'h0001);
        step();
        chk("halt.idle.addr", imem_addr, 16'h000A);

        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        step();
        redirect = 1'b0;
        chk("resume.halted", {15'd0, halted}, 16'h0000);
        chk("resume.en", {15'd0, imem_en}, 16'h0001);
        chk("resume.addr", imem_addr, 16'h0010);
        step();
        chk_ifid("resume", 1'b1, 16'h4A10, 16'h0010, 16'h0012);

        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        chk("wrap.addr0", imem_addr, 16'hFFFE);
        step();
        chk_ifid("wrap", 1'b1, 16'h4FFE, 16'hFFFE, 16'h0000);
        chk("wrap.addr1", imem_addr, 16'h0000);

        redirect    = 1'b1;
        redirect_pc = 16'h0021;
        step();
        chk("mis.err", {15'd0, err}, 16'h0001);
        chk("mis.en", {15'd0, imem_en}, 16'h0000);
        chk("mis.valid", {15'd0, if_valid}, 16'h0000);
        chk("mis.addr", imem_addr, 16'h0000);
        redirect_pc = 16'h0030;
        step();
        redirect = 1'b0;
        chk("sticky.err", {15'd0, err}, 16'h0001);
        chk("sticky.en", {15'd0, imem_en}, 16'h0000);
        chk("sticky.addr", imem_addr, 16'h0000);
        step();
        chk("sticky2.err", {15'd0, err}, 16'h0001);
        chk("sticky2.valid", {15'd0, if_valid}, 16'h0000);

        #2;
        rst = 1'b0;
        #1;
        chk_reset("async");
        step();
        chk_reset("held");
        rst = 1'b1;
        step();
        chk_ifid("restart", 1'b1, 16'h4001, 16'h0000, 16'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
